// File: rtl/iter_div_axis.sv
// iter_div_axis: iterative radix-2 restoring divider behind a dividend/divisor/dout
// stream interface. One operand pair in flight at a time. The result
// {quotient, remainder} appears WIDTH+1 clocks after the accept edge as a single-cycle
// tvalid pulse with no backpressure. tuser flags a divide by zero.
module iter_div_axis #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               abort,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   output logic               m_axis_dout_tvalid,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tuser
);

   localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     quo_q, quo_d;        // dividend magnitude shifting out, quotient bits shifting in
   logic [WIDTH-1:0]     rem_q, rem_d;        // partial remainder (magnitude)
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;      // divisor magnitude
   logic [WIDTH-1:0]     dvnd_q, dvnd_d;      // raw dividend, returned as remainder on divide by zero
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 dz_q, dz_d;
   logic                 vld_q, vld_d;
   logic [2*WIDTH-1:0]   data_q, data_d;
   logic                 user_q, user_d;

   logic                 accept;
   logic                 dvnd_neg, dvsr_neg;
   logic [WIDTH-1:0]     dvnd_abs, dvsr_abs;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH-1:0]     diff;
   logic                 fits;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Both channels transfer together, only from IDLE and never while a flush is requested.
   assign accept = (state_q == ST_IDLE) & ~abort &
                   s_axis_dividend_tvalid & s_axis_divisor_tvalid;

   assign s_axis_dividend_tready = accept;
   assign s_axis_divisor_tready  = accept;

   // Operand magnitudes; in unsigned mode the sign bits are simply ignored.
   assign dvnd_neg = SIGNED & s_axis_dividend_tdata[WIDTH-1];
   assign dvsr_neg = SIGNED & s_axis_divisor_tdata[WIDTH-1];
   assign dvnd_abs = dvnd_neg ? (~s_axis_dividend_tdata + 1'b1) : s_axis_dividend_tdata;
   assign dvsr_abs = dvsr_neg ? (~s_axis_divisor_tdata + 1'b1) : s_axis_divisor_tdata;

   // One restoring step: shift the next dividend bit into the remainder and try to
   // subtract. The remainder stays below the divisor, so when the subtraction fits the
   // difference always fits in WIDTH bits.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign fits   = (rem_sh >= {1'b0, dvsr_q});
   assign diff   = rem_sh[WIDTH-1:0] - dvsr_q;

   // Sign fix-up: quotient negative when operand signs differ, remainder follows dividend.
   assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
   assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

   // Next-state, datapath and output-register loads; abort overrides completion.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      dvnd_d    = dvnd_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      vld_d     = 1'b0;
      data_d    = data_q;
      user_d    = user_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_BUSY;
               cnt_d     = CNT_INIT;
               quo_d     = dvnd_abs;
               rem_d     = '0;
               dvsr_d    = dvsr_abs;
               dvnd_d    = s_axis_dividend_tdata;
               neg_quo_d = dvnd_neg ^ dvsr_neg;
               neg_rem_d = dvnd_neg;
               dz_d      = (s_axis_divisor_tdata == '0);
            end
         end
         ST_BUSY: begin
            if (abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               quo_d = {quo_q[WIDTH-2:0], fits};
               rem_d = fits ? diff : rem_sh[WIDTH-1:0];
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (!abort) begin
               vld_d = 1'b1;
               if (dz_q) begin
                  data_d = {{WIDTH{1'b1}}, dvnd_q};
                  user_d = 1'b1;
               end else begin
                  data_d = {quo_fix, rem_fix};
                  user_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any operation in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         dvnd_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         vld_q     <= 1'b0;
         data_q    <= '0;
         user_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         dvnd_q    <= dvnd_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         vld_q     <= vld_d;
         data_q    <= data_d;
         user_q    <= user_d;
      end
   end

   assign m_axis_dout_tvalid = vld_q;
   assign m_axis_dout_tdata  = data_q;
   assign m_axis_dout_tuser  = user_q;

endmodule
